qcw_osc: RTL and testbench

//  Phase-shifted full-bridge oscillator for the QCW driver. Generates four gate-drive
//  (GDT) signals: leg 1 (GDT1_A/B) and leg 2 (GDT2_A/B) are complementary square waves

---
 rtl/qcw_pkg.sv | 12 +
 rtl/qcw_leg.sv | 41 ++++
 rtl/qcw_osc.sv | 84 ++++++++
 tb/tb_qcw_osc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/qcw_pkg.sv
// Shared defaults and types for the QCW phase-shifted full-bridge oscillator.
package qcw_pkg;
  localparam int QCW_WIDTH      = 24;
  localparam int QCW_DEAD_TIME  = 4;
  localparam int QCW_MIN_PERIOD = 16;
  localparam int QCW_NUM_LEGS   = 2;

  typedef struct packed {
    logic a;
    logic b;
  } gdt_pair_t;
endpackage

// File: rtl/qcw_leg.sv
// One bridge leg: complementary A/B drive from a position within the period,
// with dead time before each rising edge. Outputs registered.
module qcw_leg #(
  parameter int WIDTH     = 24,
  parameter int DEAD_TIME = 4
) (
  input  logic             clk_logic,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pos,
  input  logic [WIDTH-1:0] h,
  input  logic [WIDTH-1:0] p_s,
  input  logic             run,
  output logic             a,
  output logic             b
);
  localparam logic [WIDTH-1:0] DT   = WIDTH'(DEAD_TIME);
  localparam logic [WIDTH:0]   DT_W = (WIDTH+1)'(DEAD_TIME);

  logic           a_d, a_q, b_d, b_q;
  logic [WIDTH:0] b_start;

  always_comb begin
    // one extra bit so h + dead time cannot wrap
    b_start = {1'b0, h} + DT_W;
    a_d     = run && (pos >= DT) && (pos < h);
    b_d     = run && ({1'b0, pos} >= b_start) && (pos < p_s);
  end

  always_ff @(posedge clk_logic or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign a = a_q;
  assign b = b_q;
endmodule

// File: rtl/qcw_osc.sv
// Phase-shifted full-bridge oscillator: shared period counter, shadowed
// period/phase registers updated only at period boundaries, two dead-timed legs.
module qcw_osc
  import qcw_pkg::*;
#(
  parameter int WIDTH      = QCW_WIDTH,
  parameter int DEAD_TIME  = QCW_DEAD_TIME,
  parameter int MIN_PERIOD = QCW_MIN_PERIOD
) (
  input  logic             clk_logic,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] phase_shift,
  input  logic             latch,
  input  logic             enable,
  output logic             GDT1_A,
  output logic             GDT1_B,
  output logic             GDT2_A,
  output logic             GDT2_B
);
  localparam int               NUM_LEGS = QCW_NUM_LEGS;
  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] W_MIN    = WIDTH'(MIN_PERIOD);

  logic [WIDTH-1:0] cnt_d, cnt_q, p_s_d, p_s_q, ph_s_d, ph_s_q, h;
  logic             run_d, run_q, wrap, load, leg_run;
  logic [NUM_LEGS-1:0][WIDTH-1:0] pos;
  gdt_pair_t [NUM_LEGS-1:0]       legs;

  always_comb begin
    wrap   = run_q && (cnt_q == p_s_q - W_ONE);
    // shadows follow the inputs while idle, otherwise only at the period boundary
    load   = latch && (period >= W_MIN) && (!run_q || wrap);
    p_s_d  = p_s_q;
    ph_s_d = ph_s_q;
    if (load) begin
      p_s_d  = period;
      ph_s_d = (phase_shift > period - W_ONE) ? period - W_ONE : phase_shift;
    end
    run_d = enable && ((p_s_q != '0) || load);
    cnt_d = '0;
    if (run_d && run_q && !wrap) cnt_d = cnt_q + W_ONE;
  end

  always_ff @(posedge clk_logic or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      p_s_q  <= '0;
      ph_s_q <= '0;
      run_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_s_q  <= p_s_d;
      ph_s_q <= ph_s_d;
      run_q  <= run_d;
    end
  end

  always_comb begin
    h       = p_s_q >> 1;
    leg_run = run_q && enable;
    pos[0]  = cnt_q;
    // ph_s_q <= p_s_q-1, so p_s_q - ph_s_q never underflows and the sum stays < p_s_q
    pos[1]  = (cnt_q >= ph_s_q) ? cnt_q - ph_s_q : cnt_q + (p_s_q - ph_s_q);
  end

  for (genvar g = 0; g < NUM_LEGS; g++) begin : g_leg
    qcw_leg #(.WIDTH(WIDTH), .DEAD_TIME(DEAD_TIME)) u_leg (
      .clk_logic (clk_logic),
      .reset_n   (reset_n),
      .pos       (pos[g]),
      .h         (h),
      .p_s       (p_s_q),
      .run       (leg_run),
      .a         (legs[g].a),
      .b         (legs[g].b)
    );
  end

  assign GDT1_A = legs[0].a;
  assign GDT1_B = legs[0].b;
  assign GDT2_A = legs[1].a;
  assign GDT2_B = legs[1].b;
endmodule

// File: tb/tb_qcw_osc.sv
// Bench for qcw_osc: per-cycle scoreboard against a behavioural model, plus
// directed pulse-width, dead-time, phase-lag and latency checks.
module tb_qcw_osc;
  localparam int W = 24;

  logic         clk_logic = 1'b0;
  logic         reset_n;
  logic [W-1:0] period, phase_shift;
  logic         latch, enable;
  logic         GDT1_A, GDT1_B, GDT2_A, GDT2_B;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb[$];
  int   m_cnt, m_p, m_ph;
  bit   m_run;
  logic [3:0] m_exp;

  qcw_osc dut (
    .clk_logic   (clk_logic),
    .reset_n     (reset_n),
    .period      (period),
    .phase_shift (phase_shift),
    .latch       (latch),
    .enable      (enable),
    .GDT1_A      (GDT1_A),
    .GDT1_B      (GDT1_B),
    .GDT2_A      (GDT2_A),
    .GDT2_B      (GDT2_B)
  );

  always #5 clk_logic = ~clk_logic;

  function automatic logic [1:0] leg(int pos, int p);
    int h = p / 2;
    logic [1:0] r;
    r[0] = (pos >= 4) && (pos < h);
    r[1] = (pos >= h + 4) && (pos < p);
    return r;
  endfunction

  // model of the edge about to come; the expected registered outputs are queued
  task automatic tick();
    logic [3:0] e;
    bit wrap, ld, nrun;
    e = '0;
    if (!reset_n) begin
      m_cnt = 0; m_p = 0; m_ph = 0; m_run = 0;
    end else begin
      if (m_run && enable) begin
        e[1:0] = leg(m_cnt, m_p);
        e[3:2] = leg((m_cnt - m_ph + m_p) % m_p, m_p);
      end
      wrap = m_run && (m_cnt == m_p - 1);
      ld   = latch && (period >= 16) && (!m_run || wrap);
      nrun = enable && (m_p != 0 || ld);
      if (!nrun)      m_cnt = 0;
      else if (m_run) m_cnt = wrap ? 0 : m_cnt + 1;
      if (ld) begin
        m_p  = int'(period);
        m_ph = (int'(phase_shift) > m_p - 1) ? m_p - 1 : int'(phase_shift);
      end
      m_run = nrun;
    end
    m_exp = e;
    sb.push_back(e);
    @(negedge clk_logic);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // scoreboard monitor: outputs are compared every cycle against the queued model
  always @(posedge clk_logic) begin
    logic [3:0] g, e;
    #1;
    g = {GDT2_B, GDT2_A, GDT1_B, GDT1_A};
    checks++;
    if ((g[0] & g[1]) | (g[2] & g[3])) begin
      errors++;
      $display("FAIL overlap t=%0t gdt=%b", $time, g);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        if (errors < 20) $display("FAIL scoreboard t=%0t got %b want %b", $time, g, e);
      end
    end
  end

  task automatic measure(input int p, output int a1, output int b1, output int lo1,
                         output int lag, output int diff);
    int r1, r2;
    logic pa1, pa2;
    a1 = 0; b1 = 0; lo1 = 0; diff = 0; r1 = -1; r2 = -1;
    pa1 = GDT1_A; pa2 = GDT2_A;
    for (int i = 0; i < p; i++) begin
      tick();
      if (GDT1_A) a1++;
      if (GDT1_B) b1++;
      if (!GDT1_A && !GDT1_B) lo1++;
      if (GDT1_A && !pa1) r1 = i;
      if (GDT2_A && !pa2) r2 = i;
      if ({GDT2_A, GDT2_B} !== {GDT1_A, GDT1_B}) diff++;
      pa1 = GDT1_A; pa2 = GDT2_A;
    end
    lag = (r1 < 0 || r2 < 0) ? -1 : (r2 - r1 + p) % p;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int a1, b1, lo1, lag, diff, n, hi, last_rise, first_iv, last_iv, nrise;
    logic pa;
    reset_n = 1'b0; enable = 1'b0; latch = 1'b0; period = '0; phase_shift = '0;
    @(negedge clk_logic);
    tick(); tick();
    chk("reset_state", int'({GDT2_B, GDT2_A, GDT1_B, GDT1_A}), 0);
    reset_n = 1'b1;
    tick();

    // period below the minimum never starts the bridge
    period = 10; phase_shift = 3; latch = 1'b1; enable = 1'b1;
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (GDT1_A | GDT1_B | GDT2_A | GDT2_B) hi++;
    end
    chk("short_period_idle", hi, 0);

    // nominal run: 777 cycles, leg 2 lags by 194
    period = 777; phase_shift = 194;
    run_ticks(800);
    measure(777, a1, b1, lo1, lag, diff);
    chk("p777_a_width", a1, 384);
    chk("p777_b_width", b1, 385);
    chk("p777_dead_total", lo1, 8);
    chk("p777_lag194", lag, 194);

    phase_shift = 0;
    run_ticks(800);
    measure(777, a1, b1, lo1, lag, diff);
    chk("ph0_lag", lag, 0);
    chk("ph0_legs_equal", diff, 0);

    phase_shift = 388;
    run_ticks(800);
    measure(777, a1, b1, lo1, lag, diff);
    chk("ph388_lag", lag, 388);

    phase_shift = 900;
    run_ticks(800);
    measure(777, a1, b1, lo1, lag, diff);
    chk("ph900_clamped_lag", lag, 776);

    // latch low: a new period is ignored
    phase_shift = 194;
    run_ticks(800);
    latch = 1'b0; period = 500;
    run_ticks(800);
    measure(777, a1, b1, lo1, lag, diff);
    chk("nolatch_a_width", a1, 384);
    chk("nolatch_lag", lag, 194);

    // latch high mid-period: current 777 period completes, then 500
    n = 0; pa = GDT1_A;
    while (!(GDT1_A && !pa) && n < 1000) begin pa = GDT1_A; tick(); n++; end
    chk("rise_found", int'(n < 1000), 1);
    latch = 1'b1;
    last_rise = 0; first_iv = -1; last_iv = -1; nrise = 0; pa = GDT1_A;
    for (int i = 1; i <= 1600; i++) begin
      tick();
      if (GDT1_A && !pa) begin
        if (nrise == 0) first_iv = i - last_rise;
        last_iv = i - last_rise;
        last_rise = i;
        nrise++;
      end
      pa = GDT1_A;
    end
    chk("switch_first_iv", first_iv, 777);
    chk("switch_next_iv", last_iv, 500);
    measure(500, a1, b1, lo1, lag, diff);
    chk("p500_a_width", a1, 246);
    chk("p500_b_width", b1, 246);

    // hard stop and restart from cnt=0
    run_ticks(123);
    enable = 1'b0;
    tick();
    chk("hard_stop", int'({GDT2_B, GDT2_A, GDT1_B, GDT1_A}), 0);
    run_ticks(10);
    enable = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!GDT1_A && n < 1000);
    chk("restart_latency", n, 6);

    // asynchronous reset while a gate is high
    n = 0;
    while (!m_exp[0] && n < 1000) begin tick(); n++; end
    chk("pre_reset_high", int'(GDT1_A), 1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", int'({GDT2_B, GDT2_A, GDT1_B, GDT1_A}), 0);
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (GDT1_A | GDT1_B | GDT2_A | GDT2_B) hi++;
    end
    chk("post_reset_idle", hi, 0);

    @(posedge clk_logic);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
